// File: rtl/hmi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : hmi_pkg                                            |
// | Description : Shared types and constants for the HMI readout     |
// |               path: FSM state encoding, frame header prefix and  |
// |               default parameter values.                          |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package hmi_pkg;

  // Readout FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    CAPTURE   = 3'd2,
    SEND      = 3'd3,
    WAIT_ACK  = 3'd4,
    WAIT_DONE = 3'd5
  } hmi_state_t;

  // Marks a byte as a readout frame header on the host link
  localparam logic [1:0] c_hdr_prefix = 2'b10;

  localparam int c_data_bytes_def  = 4;
  localparam int c_ack_timeout_def = 16;

  // Header byte sent ahead of the register contents
  function automatic logic [7:0] hdr_byte(input logic [5:0] addr);
    return {c_hdr_prefix, addr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hmi_timeout.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : hmi_timeout                                        |
// | Description : Down-counter guarding the transmitter acknowledge. |
// |               load arms it, enable counts, expire flags the last |
// |               enabled cycle of the window.                       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module hmi_timeout
  import hmi_pkg::*;
#(
  parameter int TIMEOUT = c_ack_timeout_def
) (
  input  logic clk,
  input  logic res_n,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int c_w = $clog2(TIMEOUT + 1);

  logic [c_w-1:0] r_cnt;

  // Reload on arm, count down while the window is open
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= c_w'(TIMEOUT);
    end else if (enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_w'(1);
    end
  end

  // Last enabled cycle of the window: TIMEOUT cycles have elapsed
  assign expire = enable && (r_cnt == c_w'(1));

endmodule
`default_nettype wire

// File: rtl/hmi_readout.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : hmi_readout                                        |
// | Description : Reads one register from the bank on request and    |
// |               streams a header byte plus DATA_BYTES data bytes   |
// |               (MSB first) to the host transmitter.               |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module hmi_readout
  import hmi_pkg::*;
#(
  parameter int DATA_BYTES  = c_data_bytes_def,
  parameter int ACK_TIMEOUT = c_ack_timeout_def
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        read,
  input  logic [5:0]  address,
  input  logic        fpga_sel,
  output logic        rd_en,
  output logic [5:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        busy,
  output logic        dropped,
  output logic        tx_err
);

  // Index of the last data byte; byte 0 is the header
  localparam logic [2:0] c_last = 3'(DATA_BYTES);

  hmi_state_t  r_state;
  logic        r_rd_en;
  logic [5:0]  r_rd_addr;
  logic [31:0] r_shift;
  logic [2:0]  r_byte_cnt;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;
  logic        r_dropped;
  logic        r_tx_err;

  logic        w_tmo_load;
  logic        w_tmo_enable;
  logic        w_tmo_expire;

  // Arm the acknowledge window on the byte launch, count while waiting
  assign w_tmo_load   = (r_state == SEND) && !tx_busy;
  assign w_tmo_enable = (r_state == WAIT_ACK);

  hmi_timeout #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .res_n  (res_n),
    .load   (w_tmo_load),
    .enable (w_tmo_enable),
    .expire (w_tmo_expire)
  );

  // Readout sequencer with all outputs registered
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state    <= IDLE;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_dropped  <= 1'b0;
      r_tx_err   <= 1'b0;
    end else begin
      r_rd_en    <= 1'b0;
      r_tx_start <= 1'b0;
      // Requests are only taken in IDLE; anything else is rejected, even
      // in the cycle the frame finishes
      r_dropped  <= read && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (read && fpga_sel) begin
            r_rd_addr <= address;
            r_rd_en   <= 1'b1;
            r_state   <= FETCH;
          end
        end
        FETCH: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_shift    <= rd_data;
          r_byte_cnt <= '0;
          r_state    <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            if (r_byte_cnt == '0) begin
              r_tx_data <= hdr_byte(r_rd_addr);
            end else begin
              r_tx_data <= r_shift[31:24];
              r_shift   <= {r_shift[23:0], 8'h00};
            end
            r_state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            r_state <= WAIT_DONE;
          end else if (w_tmo_expire) begin
            r_tx_err <= 1'b1;
            r_state  <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            r_byte_cnt <= r_byte_cnt + 3'd1;
            r_state    <= (r_byte_cnt < c_last) ? SEND : IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rd_en    = r_rd_en;
  assign rd_addr  = r_rd_addr;
  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign busy     = (r_state != IDLE);
  assign dropped  = r_dropped;
  assign tx_err   = r_tx_err;

endmodule
`default_nettype wire

// File: tb/tb_hmi_readout.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_hmi_readout                                     |
// | Description : Directed bench for hmi_readout: one default        |
// |               instance and one with DATA_BYTES=2, each with a    |
// |               simple transmitter model.                          |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_hmi_readout;

  logic        clk = 1'b0;
  logic        res_n;

  // Instance A: default parameters
  logic        read_a, fpga_sel_a, rd_en_a, tx_start_a, tx_busy_a;
  logic        busy_a, dropped_a, tx_err_a;
  logic [5:0]  address_a, rd_addr_a;
  logic [31:0] rd_data_a;
  logic [7:0]  tx_data_a;

  // Instance B: DATA_BYTES = 2
  logic        read_b, fpga_sel_b, rd_en_b, tx_start_b, tx_busy_b;
  logic        busy_b, dropped_b, tx_err_b;
  logic [5:0]  address_b, rd_addr_b;
  logic [31:0] rd_data_b;
  logic [7:0]  tx_data_b;

  // Transmitter model controls
  int          busy_len;
  logic        no_ack;
  int          tcnt_a, tcnt_b;

  // Observation
  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];
  int          n_drop_a, n_rden_a, n_txs_a, stab_err_a;

  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  hmi_readout u_dut_a (
    .clk      (clk),
    .res_n    (res_n),
    .read     (read_a),
    .address  (address_a),
    .fpga_sel (fpga_sel_a),
    .rd_en    (rd_en_a),
    .rd_addr  (rd_addr_a),
    .rd_data  (rd_data_a),
    .tx_data  (tx_data_a),
    .tx_start (tx_start_a),
    .tx_busy  (tx_busy_a),
    .busy     (busy_a),
    .dropped  (dropped_a),
    .tx_err   (tx_err_a)
  );

  hmi_readout #(
    .DATA_BYTES  (2),
    .ACK_TIMEOUT (16)
  ) u_dut_b (
    .clk      (clk),
    .res_n    (res_n),
    .read     (read_b),
    .address  (address_b),
    .fpga_sel (fpga_sel_b),
    .rd_en    (rd_en_b),
    .rd_addr  (rd_addr_b),
    .rd_data  (rd_data_b),
    .tx_data  (tx_data_b),
    .tx_start (tx_start_b),
    .tx_busy  (tx_busy_b),
    .busy     (busy_b),
    .dropped  (dropped_b),
    .tx_err   (tx_err_b)
  );

  // Transmitter models: busy for busy_len cycles after each accepted start
  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      tcnt_a <= 0;
      tcnt_b <= 0;
    end else begin
      if (tx_start_a && !no_ack) tcnt_a <= busy_len;
      else if (tcnt_a != 0)      tcnt_a <= tcnt_a - 1;
      if (tx_start_b && !no_ack) tcnt_b <= busy_len;
      else if (tcnt_b != 0)      tcnt_b <= tcnt_b - 1;
    end
  end
  assign tx_busy_a = (tcnt_a != 0);
  assign tx_busy_b = (tcnt_b != 0);

  // Monitor: record bytes and pulses, watch tx_data stability mid-byte
  always @(negedge clk) begin
    if (tx_start_a) begin q_a.push_back(tx_data_a); n_txs_a++; end
    if (tx_start_b) q_b.push_back(tx_data_b);
    if (dropped_a) n_drop_a++;
    if (rd_en_a)   n_rden_a++;
    if (busy_a && tx_busy_a && (q_a.size() > 0) && (tx_data_a != q_a[q_a.size()-1]))
      stab_err_a++;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare the captured byte stream of instance A (sel=0) or B (sel=1)
  task automatic check_frame(input string tag, input bit sel, input logic [39:0] exp, input int n);
    int sz;
    sz = sel ? q_b.size() : q_a.size();
    check_value({tag, "_len"}, 32'(sz), 32'(n));
    for (int i = 0; i < n; i++) begin
      logic [7:0] got;
      logic [7:0] want;
      want = exp[8*(n-1-i) +: 8];
      if (i < sz) got = sel ? q_b[i] : q_a[i];
      else        got = 8'hxx;
      check_value($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(want));
    end
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_a) break;
    end
    check_value({tag, "_idle"}, 32'(busy_a), 32'd0);
  endtask

  task automatic req_a(input logic [5:0] addr, input logic sel);
    read_a = 1'b1; address_a = addr; fpga_sel_a = sel;
    @(negedge clk);
    read_a = 1'b0;
  endtask

  initial begin
    int base_drop, base_rden, base_txs;
    logic early;

    res_n = 1'b0;
    read_a = 0; address_a = '0; fpga_sel_a = 0; rd_data_a = '0;
    read_b = 0; address_b = '0; fpga_sel_b = 1; rd_data_b = '0;
    busy_len = 10; no_ack = 0;
    n_drop_a = 0; n_rden_a = 0; n_txs_a = 0; stab_err_a = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check_value("rst_ctrl", {27'd0, busy_a, rd_en_a, tx_start_a, dropped_a, tx_err_a}, 32'd0);
    check_value("rst_tx_data", 32'(tx_data_a), 32'd0);
    check_value("rst_rd_addr", 32'(rd_addr_a), 32'd0);

    // Frame: address 15, request on the first edge after reset release
    rd_data_a = 32'hA1B2C3D4;
    res_n = 1'b1;
    req_a(6'h15, 1'b1);
    check_value("fetch_rd_en", 32'(rd_en_a), 32'd1);
    check_value("fetch_rd_addr", 32'(rd_addr_a), 32'h15);
    check_value("fetch_busy", 32'(busy_a), 32'd1);
    @(negedge clk);
    check_value("capture_rd_en", 32'(rd_en_a), 32'd0);
    @(negedge clk);
    check_value("send_no_start", 32'(tx_start_a), 32'd0);
    @(negedge clk);
    check_value("lat_tx_start", 32'(tx_start_a), 32'd1);
    check_value("lat_tx_data", 32'(tx_data_a), 32'h95);
    wait_idle_a("frame1", 300);
    check_value("frame1_txbusy_at_end", 32'(tx_busy_a), 32'd0);
    check_frame("frame1", 1'b0, 40'h95_A1_B2_C3_D4, 5);
    check_value("frame1_rd_addr_hold", 32'(rd_addr_a), 32'h15);
    check_value("frame1_no_drop", 32'(n_drop_a), 32'd0);

    // Not selected: nothing happens
    base_drop = n_drop_a; base_rden = n_rden_a; base_txs = n_txs_a;
    req_a(6'h22, 1'b0);
    early = 1'b0;
    repeat (10) begin @(negedge clk); early |= busy_a; end
    check_value("nosel_busy", 32'(early), 32'd0);
    check_value("nosel_activity", 32'(n_drop_a - base_drop + n_rden_a - base_rden + n_txs_a - base_txs), 32'd0);

    // Acknowledge timeout
    q_a.delete();
    no_ack = 1'b1;
    base_txs = n_txs_a;
    req_a(6'h15, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (tx_start_a) break;
      @(negedge clk);
    end
    check_value("tmo_start", 32'(tx_start_a), 32'd1);
    early = 1'b0;
    repeat (15) begin @(negedge clk); early |= tx_err_a; end
    check_value("tmo_early", 32'(early), 32'd0);
    @(negedge clk);
    check_value("tmo_err", 32'(tx_err_a), 32'd1);
    check_value("tmo_idle", 32'(busy_a), 32'd0);
    repeat (20) @(negedge clk);
    check_value("tmo_no_more_start", 32'(n_txs_a - base_txs), 32'd1);
    no_ack = 1'b0;

    // Second read 2 cycles into a frame, plus read on the return-to-IDLE cycle
    q_a.delete();
    rd_data_a = 32'hDEADBEEF;
    base_drop = n_drop_a;
    req_a(6'h2A, 1'b1);
    read_a = 1'b1; address_a = 6'h3F;
    @(negedge clk);
    read_a = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q_a.size() >= 5 && !tx_busy_a) break;
      @(negedge clk);
    end
    check_value("late_busy", 32'(busy_a), 32'd1);
    read_a = 1'b1; address_a = 6'h01;
    @(negedge clk);
    read_a = 1'b0;
    check_value("late_dropped", 32'(dropped_a), 32'd1);
    check_value("late_idle", 32'(busy_a), 32'd0);
    repeat (5) @(negedge clk);
    check_value("late_not_taken", 32'(busy_a), 32'd0);
    check_value("drop_count", 32'(n_drop_a - base_drop), 32'd2);
    check_frame("dropf", 1'b0, 40'hAA_DE_AD_BE_EF, 5);
    check_value("err_sticky", 32'(tx_err_a), 32'd1);
    check_value("stability", 32'(stab_err_a), 32'd0);

    // Reset during the third byte, then a fresh request
    q_a.delete();
    rd_data_a = 32'hA1B2C3D4;
    req_a(6'h15, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (q_a.size() >= 3) break;
      @(negedge clk);
    end
    check_value("mid_third_byte", 32'(q_a.size()), 32'd3);
    res_n = 1'b0;
    #1;
    check_value("mid_rst_ctrl", {27'd0, busy_a, rd_en_a, tx_start_a, dropped_a, tx_err_a}, 32'd0);
    check_value("mid_rst_data", {18'd0, tx_data_a, rd_addr_a}, 32'd0);
    q_a.delete();
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    req_a(6'h01, 1'b1);
    wait_idle_a("postrst", 300);
    check_frame("postrst", 1'b0, 40'h81_A1_B2_C3_D4, 5);

    // DATA_BYTES = 2 instance
    rd_data_b = 32'h1234_5678;
    read_b = 1'b1; address_b = 6'h00;
    @(negedge clk);
    read_b = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_b) break;
    end
    check_value("b_idle", 32'(busy_b), 32'd0);
    check_frame("b", 1'b1, {16'h0, 24'h80_12_34}, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
